sort_hw_bubble_master: RTL and testbench

- Avalon-MM master that sorts a contiguous block of 32-bit words in place, ascending, inside the sort_hw on-chip data RAM.
- Drives the RAM slave port (11-bit word address, 4-bit byteenable, chipselect/write, fixed 1-cycle read latency, no waitrequest).
- Runs bubble sort with early exit when a pass makes no swaps.
- Controlled by a start/busy/done handshake from the sort_hw control logic.

---
 rtl/sort_hw_bubble_master.sv | 234 +++++++++++++++++++++++
 tb/tb_sort_hw_bubble_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_hw_bubble_master.sv
`timescale 1ns/1ps
// sort_hw_bubble_master
//   Avalon-MM master that sorts a contiguous block of DATA_W-bit words in
//   place, in ascending order, inside the sort_hw data RAM. It uses bubble
//   sort and stops early when a pass makes no swaps. Equal keys are never
//   swapped, so the sort is stable.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   start           one-cycle request, sampled only while idle
//   base_addr       first word address, sampled with start
//   length          word count 0..2^ADDR_W, sampled with start
//   busy            high from the cycle after start until DONE is left
//   done            one-cycle completion pulse
//   swap_count      swaps made in the last run, saturating at 16'hFFFF
//   avm_*           RAM slave port: 1-cycle read latency, no waitrequest
//
// Every output is a register. The output process derives its values from
// the *next* state, so the bus strobes line up with the state they belong to.
module sort_hw_bubble_master #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 11,
   parameter int SIGNED_CMP = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [15:0]       swap_count,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [3:0]        avm_byteenable,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_A, S_RD_B, S_WAIT, S_CMP, S_WR_A, S_WR_B, S_NEXT, S_DONE
   } state_t;

   localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   LEN_TWO = (ADDR_W+1)'(2);
   localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

   state_t state_q, state_d;

   // Datapath registers. i never exceeds 2^ADDR_W-2, so ADDR_W bits suffice;
   // limit needs one extra bit only to hold length-1 without truncation logic.
   logic [ADDR_W-1:0] base_q,  base_d;
   logic [ADDR_W-1:0] i_q,     i_d;
   logic [ADDR_W:0]   limit_q, limit_d;
   logic [DATA_W-1:0] a_q,     a_d;
   logic [DATA_W-1:0] b_q,     b_d;
   logic              swapped_q, swapped_d;
   logic [15:0]       swap_cnt_q, swap_cnt_d;

   // Registered outputs
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              cs_q,   cs_d;
   logic              wr_q,   wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              a_gt_b;
   logic [ADDR_W-1:0] idx;

   generate
      if (SIGNED_CMP != 0) begin : g_signed_cmp
         assign a_gt_b = $signed(a_q) > $signed(b_q);
      end else begin : g_unsigned_cmp
         assign a_gt_b = a_q > b_q;
      end
   endgenerate

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state and datapath ----------------
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      i_d        = i_q;
      limit_d    = limit_q;
      a_d        = a_q;
      b_d        = b_q;
      swapped_d  = swapped_q;
      swap_cnt_d = swap_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d     = base_addr;
               swap_cnt_d = '0;
               if (length < LEN_TWO) begin
                  state_d = S_DONE;
               end else begin
                  i_d       = '0;
                  limit_d   = length - LEN_ONE;
                  swapped_d = 1'b0;
                  state_d   = S_RD_A;
               end
            end
         end
         S_RD_A: state_d = S_RD_B;
         S_RD_B: begin
            // Word at base+i arrives now (requested in RD_A)
            a_d     = avm_readdata;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            b_d     = avm_readdata;
            state_d = S_CMP;
         end
         S_CMP:  state_d = a_gt_b ? S_WR_A : S_NEXT;
         S_WR_A: state_d = S_WR_B;
         S_WR_B: begin
            swapped_d = 1'b1;
            if (swap_cnt_q != 16'hFFFF) begin
               swap_cnt_d = swap_cnt_q + 16'd1;
            end
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (({1'b0, i_q} + LEN_ONE) < limit_q) begin
               i_d     = i_q + ADR_ONE;
               state_d = S_RD_A;
            end else if (!swapped_q || limit_q == LEN_ONE) begin
               state_d = S_DONE;
            end else begin
               // The largest remaining element has bubbled into place
               limit_d   = limit_q - LEN_ONE;
               i_d       = '0;
               swapped_d = 1'b0;
               state_d   = S_RD_A;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- output logic (from next state) ----------------
   // Address arithmetic wraps modulo 2^ADDR_W, so a block may straddle the
   // top of the RAM.
   assign idx = base_d + i_d;

   always_comb begin
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      cs_d    = 1'b0;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_d)
         S_RD_A: begin
            cs_d   = 1'b1;
            addr_d = idx;
         end
         S_RD_B: begin
            cs_d   = 1'b1;
            addr_d = idx + ADR_ONE;
         end
         S_WR_A: begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = idx;
            wdata_d = b_d;
         end
         S_WR_B: begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = idx + ADR_ONE;
            wdata_d = a_d;
         end
         default: begin
            cs_d = 1'b0;
         end
      endcase
   end

   // ---------------- datapath and output registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         base_q     <= '0;
         i_q        <= '0;
         limit_q    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         swapped_q  <= 1'b0;
         swap_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         cs_q       <= 1'b0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
      end else begin
         base_q     <= base_d;
         i_q        <= i_d;
         limit_q    <= limit_d;
         a_q        <= a_d;
         b_q        <= b_d;
         swapped_q  <= swapped_d;
         swap_cnt_q <= swap_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         addr_q     <= addr_d;
         cs_q       <= cs_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign swap_count     = swap_cnt_q;
   assign avm_address    = addr_q;
   assign avm_chipselect = cs_q;
   assign avm_write      = wr_q;
   assign avm_byteenable = 4'hF;
   assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_sort_hw_bubble_master.sv
`timescale 1ns/1ps
// Bench for sort_hw_bubble_master. Two instances share stimulus: u_dut_u
// compares unsigned, u_dut_s compares signed. Each has its own RAM model
// with a registered (1-cycle) read. Expected values are hand-computed.
module tb_sort_hw_bubble_master;

   logic        clk;
   logic        reset;
   logic        start;
   logic [10:0] base_addr;
   logic [11:0] length;

   logic        busy0, done0, cs0, wr0;
   logic [15:0] swc0;
   logic [10:0] addr0;
   logic [3:0]  be0;
   logic [31:0] wd0, rd0;

   logic        busy1, done1, cs1, wr1;
   logic [15:0] swc1;
   logic [10:0] addr1;
   logic [3:0]  be1;
   logic [31:0] wd1, rd1;

   logic [31:0] mem0 [0:2047];
   logic [31:0] mem1 [0:2047];

   logic        ld_en;
   logic [10:0] ld_addr;
   logic [31:0] ld_data;
   logic        clr;
   int          wr_cnt0, cs_cnt0, done_cnt0, busy_cnt0;

   int tests_run;
   int tests_failed;
   int n0, n1;
   int snap;
   logic found, prev_wr;

   sort_hw_bubble_master #(.DATA_W(32), .ADDR_W(11), .SIGNED_CMP(0)) u_dut_u (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy0), .done(done0), .swap_count(swc0),
      .avm_address(addr0), .avm_chipselect(cs0), .avm_write(wr0),
      .avm_byteenable(be0), .avm_writedata(wd0), .avm_readdata(rd0)
   );

   sort_hw_bubble_master #(.DATA_W(32), .ADDR_W(11), .SIGNED_CMP(1)) u_dut_s (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy1), .done(done1), .swap_count(swc1),
      .avm_address(addr1), .avm_chipselect(cs1), .avm_write(wr1),
      .avm_byteenable(be1), .avm_writedata(wd1), .avm_readdata(rd1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM models plus a preload port that writes both copies
   always @(posedge clk) begin
      if (ld_en) begin
         mem0[ld_addr] <= ld_data;
         mem1[ld_addr] <= ld_data;
      end else begin
         if (cs0 && wr0) mem0[addr0] <= wd0;
         if (cs1 && wr1) mem1[addr1] <= wd1;
      end
      rd0 <= mem0[addr0];
      rd1 <= mem1[addr1];
   end

   // Bus / handshake activity counters for the unsigned instance
   always @(posedge clk) begin
      if (clr) begin
         wr_cnt0   <= 0;
         cs_cnt0   <= 0;
         done_cnt0 <= 0;
         busy_cnt0 <= 0;
      end else begin
         if (cs0 && wr0) wr_cnt0 <= wr_cnt0 + 1;
         if (cs0)        cs_cnt0 <= cs_cnt0 + 1;
         if (done0)      done_cnt0 <= done_cnt0 + 1;
         if (busy0)      busy_cnt0 <= busy_cnt0 + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_word(input logic [10:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   task automatic clear_counts();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Start a run; returns the cycle (1 = first cycle after the start edge)
   // in which each instance raised done. A second start is pulsed in cycle
   // restart_at when it is non-zero.
   task automatic run(input logic [10:0] b, input logic [11:0] len,
                      input int restart_at, output int c0, output int c1);
      int n;
      clear_counts();
      @(negedge clk);
      base_addr = b;
      length    = len;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c0 = 0;
      c1 = 0;
      n  = 1;
      while (n < 3000) begin
         if (n == restart_at) begin
            start     = 1'b1;
            base_addr = 11'd0;
            length    = 12'd0;
         end else begin
            start = 1'b0;
         end
         if (done0 && c0 == 0) c0 = n;
         if (done1 && c1 == 0) c1 = n;
         if (c0 != 0 && c1 != 0) break;
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      chk("run_completes", {31'd0, (c0 != 0 && c1 != 0)}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      $display("[TB] run base=%0d len=%0d done_cycle_u=%0d done_cycle_s=%0d swaps_u=%0d swaps_s=%0d",
               b, len, c0, c1, swc0, swc1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      ld_en     = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;
      clr       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  {31'd0, busy0}, 32'd0);
      chk("rst_done",  {31'd0, done0}, 32'd0);
      chk("rst_cs",    {31'd0, cs0},   32'd0);
      chk("rst_write", {31'd0, wr0},   32'd0);
      chk("rst_addr",  {21'd0, addr0}, 32'd0);
      chk("rst_wdata", wd0,            32'd0);
      chk("rst_swaps", {16'd0, swc0},  32'd0);
      chk("byteenable", {28'd0, be0},  32'hF);
      reset = 1'b0;
      clr   = 1'b0;

      // Reverse-ordered block: 3+2+1 swaps, 6 swaps x 7 cycles, done in 43
      load_word(11'd0, 32'd4);
      load_word(11'd1, 32'd3);
      load_word(11'd2, 32'd2);
      load_word(11'd3, 32'd1);
      run(11'd0, 12'd4, 0, n0, n1);
      chk("rev_w0", mem0[0], 32'd1);
      chk("rev_w1", mem0[1], 32'd2);
      chk("rev_w2", mem0[2], 32'd3);
      chk("rev_w3", mem0[3], 32'd4);
      chk("rev_swaps", {16'd0, swc0}, 32'd6);
      chk("rev_writes", wr_cnt0, 32'd12);
      chk("rev_done_pulses", done_cnt0, 32'd1);
      chk("rev_done_cycle", n0, 32'd43);

      // length=1: done in cycle 1, no bus activity, swap_count cleared
      run(11'd7, 12'd1, 0, n0, n1);
      chk("len1_done_cycle", n0, 32'd1);
      chk("len1_cs", cs_cnt0, 32'd0);
      chk("len1_busy_cycles", busy_cnt0, 32'd1);
      chk("len1_swaps", {16'd0, swc0}, 32'd0);

      // Already sorted: one pass, 4 comparisons x 5 cycles, done in 21
      load_word(11'd9,  32'hAAAA);
      load_word(11'd10, 32'd1);
      load_word(11'd11, 32'd2);
      load_word(11'd12, 32'd3);
      load_word(11'd13, 32'd4);
      load_word(11'd14, 32'd5);
      load_word(11'd15, 32'd0);
      run(11'd10, 12'd5, 0, n0, n1);
      chk("sorted_done_cycle", n0, 32'd21);
      chk("sorted_writes", wr_cnt0, 32'd0);
      chk("sorted_reads", cs_cnt0, 32'd8);
      chk("sorted_swaps", {16'd0, swc0}, 32'd0);
      chk("sorted_busy_cycles", busy_cnt0, 32'd21);
      chk("sorted_below", mem0[9], 32'hAAAA);
      chk("sorted_above", mem0[15], 32'd0);

      // length=0
      run(11'd5, 12'd0, 0, n0, n1);
      chk("len0_done_cycle", n0, 32'd1);
      chk("len0_cs", cs_cnt0, 32'd0);
      chk("len0_busy_cycles", busy_cnt0, 32'd1);
      chk("len0_done_pulses", done_cnt0, 32'd1);

      // Wrapping block [5,-1,7,-3] at 2046,2047,0,1
      load_word(11'd2045, 32'h66);
      load_word(11'd2046, 32'd5);
      load_word(11'd2047, 32'hFFFFFFFF);
      load_word(11'd0,    32'd7);
      load_word(11'd1,    32'hFFFFFFFD);
      load_word(11'd2,    32'h55);
      run(11'd2046, 12'd4, 0, n0, n1);
      chk("wrap_s_w0", mem1[2046], 32'hFFFFFFFD);
      chk("wrap_s_w1", mem1[2047], 32'hFFFFFFFF);
      chk("wrap_s_w2", mem1[0],    32'd5);
      chk("wrap_s_w3", mem1[1],    32'd7);
      chk("wrap_s_swaps", {16'd0, swc1}, 32'd4);
      chk("wrap_u_w0", mem0[2046], 32'd5);
      chk("wrap_u_w1", mem0[2047], 32'd7);
      chk("wrap_u_w2", mem0[0],    32'hFFFFFFFD);
      chk("wrap_u_w3", mem0[1],    32'hFFFFFFFF);
      chk("wrap_u_swaps", {16'd0, swc0}, 32'd2);
      chk("wrap_below", mem0[2045], 32'h66);
      chk("wrap_above", mem0[2],    32'h55);

      // Equal keys with a stray start while busy: 5+7+7 cycles, done in 20
      load_word(11'd200, 32'd2);
      load_word(11'd201, 32'd2);
      load_word(11'd202, 32'd1);
      run(11'd200, 12'd3, 3, n0, n1);
      chk("eq_w0", mem0[200], 32'd1);
      chk("eq_w1", mem0[201], 32'd2);
      chk("eq_w2", mem0[202], 32'd2);
      chk("eq_swaps", {16'd0, swc0}, 32'd2);
      chk("eq_done_pulses", done_cnt0, 32'd1);
      chk("eq_done_cycle", n0, 32'd20);

      // Reset asserted during a WR_B cycle of a 16-word descending sort
      for (int k = 0; k < 16; k++) begin
         load_word(11'(100 + k), 32'(16 - k));
      end
      clear_counts();
      @(negedge clk);
      base_addr = 11'd100;
      length    = 12'd16;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      found   = 1'b0;
      prev_wr = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
         if (wr0 && prev_wr) begin
            found = 1'b1;
         end else begin
            prev_wr = wr0;
            @(posedge clk);
            #1;
         end
      end
      chk("rst_wrb_found", {31'd0, found}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_busy", {31'd0, busy0}, 32'd0);
      chk("midrst_done", {31'd0, done0}, 32'd0);
      chk("midrst_cs",   {31'd0, cs0},   32'd0);
      snap = wr_cnt0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("midrst_no_writes", wr_cnt0, snap);
      $display("[TB] mid-run reset applied, writes before reset=%0d", snap);
      run(11'd100, 12'd16, 0, n0, n1);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("resort_w%0d", k), mem0[100 + k], 32'(k + 1));
      end
      chk("resort_done_pulses", done_cnt0, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
